mem_responder: RTL and testbench

- Main-memory responder on the cache's memory-side port; it answers the cache's block refill and writeback requests.
- Read: one request cycle, then a whole cache block streamed back one word per cycle after a fixed access latency.
- Write: accepts a block streamed one word per cycle, then a fixed write-commit latency.
- Provides explicit valid, last, busy and ack handshakes so the cache controller no longer counts cycles blindly.

---
 rtl/mem_resp_pkg.sv | 37 +++
 rtl/mem_resp_array.sv | 37 +++
 rtl/mem_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mem_responder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
//   Shared definitions for the main-memory responder:
//     - mem_resp_state_t : responder FSM states
//     - DEF_DEPTH / DEF_BLOCK_WORDS / DEF_LATENCY : default geometry and timing
//     - block_base_word(): byte address -> block-aligned word index inside the
//       backing store (wraps modulo depth, low block bits forced to zero)
// -----------------------------------------------------------------------------
package mem_resp_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned DEF_DEPTH       = 4096;
  localparam int unsigned DEF_BLOCK_WORDS = 32;
  localparam int unsigned DEF_LATENCY     = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_WAIT   = 3'd1,
    RD_BURST  = 3'd2,
    WR_BURST  = 3'd3,
    WR_COMMIT = 3'd4
  } mem_resp_state_t;

  // Drops the byte offset, discards address bits above the array range and
  // aligns down to the start of the containing block. depth and block_words
  // are powers of two, so masking is equivalent to modulo / round-down.
  function automatic logic [31:0] block_base_word(
    input logic [31:0] byte_addr,
    input int unsigned depth,
    input int unsigned block_words
  );
    logic [31:0] word_idx;
    word_idx = (byte_addr >> 2) & (depth - 32'd1);
    return word_idx & ~(block_words - 32'd1);
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// -----------------------------------------------------------------------------
// mem_resp_array
//   Single-port DEPTH x 32 synchronous RAM. Write and read share one address;
//   the read data is registered, so rdata_o shows the word addressed in the
//   previous cycle (old contents on a same-cycle write). Contents power up as
//   zero and are not affected by any reset.
//
// Ports
//   clk_i    : clock
//   we_i     : write enable for this cycle
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : registered read data
// -----------------------------------------------------------------------------
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Main-memory responder on the cache's memory-side port. Serves block
//   refills (read bursts) and block writebacks (write bursts) against a
//   DEPTH-word backing store.
//
//   Handshake: a request is taken only while the responder is idle
//   (mem_busy=0); mem_ren starts a read, mem_wen starts a write and wins when
//   both are high. The responder never back-pressures an accepted write word
//   and never stalls a read burst: mem_valid marks each returned word for
//   exactly one cycle, mem_last qualifies the final one, and mem_ack pulses for
//   one cycle when a write burst has committed. Requests seen while busy are
//   dropped, not queued.
//
//   Read: request at cycle T, words 0..BLOCK_WORDS-1 at T+LATENCY onward,
//   idle again (and able to take a new request) the cycle after the last word.
//   Write: word 0 with the request, then one word per mem_wen cycle (mem_wen
//   low stalls), then LATENCY commit cycles with mem_ack in the last.
//
//   Optional build macro MEM_RESP_STATS_EN adds the rd_blocks / wr_blocks
//   saturating block counters.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   mem_ren    : read-block request (idle only)
//   mem_wen    : write-word strobe; first strobe while idle starts a write
//   mem_addr   : byte address, sampled on the request cycle only
//   mem_din    : write data word
//   mem_dout   : read data word, zero when mem_valid is low
//   mem_valid  : mem_dout carries a burst word
//   mem_last   : final word of a read burst
//   mem_busy   : transaction in progress
//   mem_ack    : one-cycle write-commit pulse
//   rd_blocks  : completed read bursts (MEM_RESP_STATS_EN only)
//   wr_blocks  : committed write bursts (MEM_RESP_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned LATENCY     = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_din,
  output logic [31:0]       mem_dout,
  output logic              mem_valid,
  output logic              mem_last,
  output logic              mem_busy,
  output logic              mem_ack
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0]       rd_blocks,
  output logic [31:0]       wr_blocks
`endif
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned BWB = $clog2(BLOCK_WORDS);
  localparam int unsigned CW  = BWB + 1;              // word counter width
  localparam int unsigned LW  = $clog2(LATENCY) + 1;  // latency counter width

  localparam logic [CW-1:0] BW_C   = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] BW_M1  = CW'(BLOCK_WORDS - 1);
  localparam logic [LW-1:0] LAT_M1 = LW'(LATENCY - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mem_resp_state_t state_q;
  logic [AW-1:0]   base_q;    // block base word index of current transaction
  logic [CW-1:0]   word_q;    // read: next word to fetch; write: next word slot
  logic [LW-1:0]   lat_q;     // remaining wait / commit cycles
  logic            valid_q;
  logic            last_q;
  logic            busy_q;
  logic            ack_q;

  logic [AW-1:0]   req_base;
  logic            arr_we;
  logic [AW-1:0]   arr_addr;
  logic [31:0]     arr_rdata;

  assign req_base = AW'(block_base_word(mem_addr, DEPTH, BLOCK_WORDS));

  // ---------------------------------------------------------------------------
  // Array port steering. While idle the array is addressed straight from the
  // request so that word 0 of a write lands in the request cycle, and with
  // LATENCY=1 word 0 of a read is fetched in the request cycle as well.
  // Otherwise the address is base + word counter; the base is block-aligned
  // and the counter stays below BLOCK_WORDS whenever the address matters, so
  // the sum never leaves the block.
  // ---------------------------------------------------------------------------
  always_comb begin
    arr_we   = 1'b0;
    arr_addr = base_q + AW'(word_q);
    if (state_q == IDLE) begin
      arr_addr = req_base;
      arr_we   = mem_wen;
    end else if (state_q == WR_BURST) begin
      arr_we   = mem_wen;
    end
    if (rst) begin
      arr_we = 1'b0;
    end
  end

  mem_resp_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (mem_din),
    .rdata_o (arr_rdata)
  );

  // ---------------------------------------------------------------------------
  // FSM with registered handshake outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      word_q  <= '0;
      lat_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_wen) begin
            // Write wins over a simultaneous read; word 0 is written now.
            base_q <= req_base;
            word_q <= CW'(1);
            busy_q <= 1'b1;
            if (BLOCK_WORDS == 1) begin
              state_q <= WR_COMMIT;
              lat_q   <= LAT_M1;
              ack_q   <= (LATENCY == 1);
            end else begin
              state_q <= WR_BURST;
            end
          end else if (mem_ren) begin
            base_q <= req_base;
            busy_q <= 1'b1;
            if (LATENCY == 1) begin
              // Word 0 was fetched this cycle; it shows next cycle.
              state_q <= RD_BURST;
              valid_q <= 1'b1;
              last_q  <= (BLOCK_WORDS == 1);
              word_q  <= CW'(1);
            end else begin
              state_q <= RD_WAIT;
              lat_q   <= LAT_M1;
              word_q  <= '0;
            end
          end
        end

        RD_WAIT: begin
          // lat_q runs LATENCY-1 .. 1; word 0 is fetched in the cycle with
          // lat_q == 1 so that it appears LATENCY cycles after the request.
          if (lat_q == LW'(1)) begin
            state_q <= RD_BURST;
            valid_q <= 1'b1;
            last_q  <= (word_q == BW_M1);
            word_q  <= word_q + CW'(1);
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end

        RD_BURST: begin
          // word_q is one ahead of the word on mem_dout.
          if (word_q == BW_C) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            word_q  <= '0;
          end else begin
            valid_q <= 1'b1;
            last_q  <= (word_q == BW_M1);
            word_q  <= word_q + CW'(1);
          end
        end

        WR_BURST: begin
          if (mem_wen) begin
            word_q <= word_q + CW'(1);
            if (word_q == BW_M1) begin
              state_q <= WR_COMMIT;
              lat_q   <= LAT_M1;
              ack_q   <= (LATENCY == 1);
            end
          end
        end

        WR_COMMIT: begin
          // lat_q runs LATENCY-1 .. 0; ack is raised for the lat_q == 0 cycle.
          if (lat_q == '0) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            word_q  <= '0;
          end else begin
            lat_q <= lat_q - LW'(1);
            ack_q <= (lat_q == LW'(1));
          end
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_dout  = valid_q ? arr_rdata : '0;
  assign mem_valid = valid_q;
  assign mem_last  = last_q;
  assign mem_busy  = busy_q;
  assign mem_ack   = ack_q;

`ifdef MEM_RESP_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating block counters
  // ---------------------------------------------------------------------------
  logic [31:0] rd_blocks_q;
  logic [31:0] wr_blocks_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_blocks_q <= '0;
      wr_blocks_q <= '0;
    end else begin
      if (last_q && (rd_blocks_q != '1)) begin
        rd_blocks_q <= rd_blocks_q + 32'd1;
      end
      if (ack_q && (wr_blocks_q != '1)) begin
        wr_blocks_q <= wr_blocks_q + 32'd1;
      end
    end
  end

  assign rd_blocks = rd_blocks_q;
  assign wr_blocks = wr_blocks_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder. The reference is a plain word array
//   updated on every write burst; each read burst's expected words are queued
//   from it and popped as mem_valid words arrive. Cycle positions of valid,
//   last, busy and ack are derived from the request cycle and LATENCY.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int DEPTH = 4096;
  localparam int BW    = 32;
  localparam int LAT   = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_din = '0;
  logic [31:0] mem_dout;
  logic        mem_valid;
  logic        mem_last;
  logic        mem_busy;
  logic        mem_ack;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] rd_blocks;
  logic [31:0] wr_blocks;
`endif

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH       (DEPTH),
    .BLOCK_WORDS (BW),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_valid (mem_valid),
    .mem_last  (mem_last),
    .mem_busy  (mem_busy),
    .mem_ack   (mem_ack)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_blocks (rd_blocks),
    .wr_blocks (wr_blocks)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard state
  // ---------------------------------------------------------------------------
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wbuf [BW];
  logic [31:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int n_rd     = 0;
  int n_wr     = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_w0;
    int          poke;   // cycle offset of a stray mem_ren while busy, 0 = none
  } rd_vec_t;

  rd_vec_t rd_vecs [6];

  function automatic int model_base(input logic [31:0] addr);
    int widx;
    widx = int'(addr >> 2) % DEPTH;
    return (widx / BW) * BW;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: read burst. Called in an idle cycle; returns in the first idle
  // cycle after the burst, so calls can be chained back to back.
  // ---------------------------------------------------------------------------
  task automatic do_read(input logic [31:0] addr, input int poke, output logic [31:0] first_word);
    int base;
    int got;
    logic [31:0] w;
    base = model_base(addr);
    got = 0;
    first_word = 32'hxxxxxxxx;
    exp_q.delete();
    for (int k = 0; k < BW; k++) exp_q.push_back(ref_mem[(base + k) % DEPTH]);
    check("rd_req_busy", {31'd0, mem_busy}, 32'd0);
    mem_ren  = 1'b1;
    mem_addr = addr;
    for (int j = 1; j <= LAT + BW; j++) begin
      step();
      check("rd_valid", {31'd0, mem_valid}, {31'd0, (j >= LAT && j < LAT + BW)});
      check("rd_last", {31'd0, mem_last}, {31'd0, (j == LAT + BW - 1)});
      check("rd_busy", {31'd0, mem_busy}, {31'd0, (j < LAT + BW)});
      if (mem_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_extra_word", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("rd_data", mem_dout, w);
          if (got == 0) first_word = mem_dout;
          got++;
        end
      end
      mem_ren  = (j == poke);
      mem_addr = (j == poke) ? $urandom : addr;
    end
    mem_ren = 1'b0;
    check("rd_missing_words", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    n_rd++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: write burst of wbuf[]. stall_len idle cycles are inserted after
  // word stall_after. with_ren raises mem_ren in the request cycle too.
  // Returns in the first idle cycle after mem_ack.
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [31:0] addr, input int stall_after, input int stall_len,
                          input logic with_ren);
    int base;
    int k;
    int stalls;
    int ack_at;
    base   = model_base(addr);
    stalls = stall_len;
    ack_at = -1;
    check("wr_req_busy", {31'd0, mem_busy}, 32'd0);
    mem_wen  = 1'b1;
    mem_ren  = with_ren;
    mem_addr = addr;
    mem_din  = wbuf[0];
    ref_mem[base] = wbuf[0];
    k = 1;
    while (k < BW) begin
      step();
      check("wr_busy", {31'd0, mem_busy}, 32'd1);
      check("wr_no_valid", {31'd0, mem_valid}, 32'd0);
      check("wr_no_ack", {31'd0, mem_ack}, 32'd0);
      mem_ren  = 1'b0;
      mem_addr = $urandom;
      if (k == stall_after + 1 && stalls > 0) begin
        mem_wen = 1'b0;
        mem_din = $urandom;
        stalls--;
      end else begin
        mem_wen = 1'b1;
        mem_din = wbuf[k];
        ref_mem[(base + k) % DEPTH] = wbuf[k];
        k++;
      end
    end
    for (int j = 1; j <= LAT + 8; j++) begin
      step();
      mem_wen = 1'b0;
      mem_din = $urandom;
      check("wr_commit_busy", {31'd0, mem_busy}, 32'd1);
      check("wr_commit_no_valid", {31'd0, mem_valid}, 32'd0);
      if (mem_ack) begin
        ack_at = j;
        break;
      end
    end
    check("wr_ack_latency", 32'(ack_at), 32'(LAT));
    step();
    check("wr_ack_pulse", {31'd0, mem_ack}, 32'd0);
    check("wr_busy_drop", {31'd0, mem_busy}, 32'd0);
    n_wr++;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] w0;
    logic [31:0] a;
    logic [31:0] last_wr_addr;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_dout", mem_dout, 32'd0);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_last", {31'd0, mem_last}, 32'd0);
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    check("rst_ack", {31'd0, mem_ack}, 32'd0);
`ifdef MEM_RESP_STATS_EN
    check("rst_rd_blocks", rd_blocks, 32'd0);
    check("rst_wr_blocks", wr_blocks, 32'd0);
`endif
    rst = 1'b0;
    step();

    // Read of never-written memory at address 0
    do_read(32'h0000_0000, 0, w0);
    check("rd0_word0", w0, 32'd0);

    // Write burst 0xDEAD0000+k to 0x1000
    for (int k = 0; k < BW; k++) wbuf[k] = 32'hDEAD0000 + 32'(k);
    do_write(32'h0000_1000, -1, 0, 1'b0);

    // Table-driven reads, back to back: alignment, wrap, block boundaries,
    // and a stray request while busy.
    rd_vecs[0] = '{addr: 32'h0000_1000, exp_w0: 32'hDEAD0000, poke: 0};
    rd_vecs[1] = '{addr: 32'h0000_1044, exp_w0: 32'hDEAD0000, poke: 0};
    rd_vecs[2] = '{addr: 32'h0000_5000, exp_w0: 32'hDEAD0000, poke: 10};
    rd_vecs[3] = '{addr: 32'h0000_107C, exp_w0: 32'hDEAD0000, poke: 0};
    rd_vecs[4] = '{addr: 32'h0000_0FFC, exp_w0: 32'h0000_0000, poke: 0};
    rd_vecs[5] = '{addr: 32'h0000_1080, exp_w0: 32'h0000_0000, poke: 20};
    for (int i = 0; i < 6; i++) begin
      do_read(rd_vecs[i].addr, rd_vecs[i].poke, w0);
      check("tbl_word0", w0, rd_vecs[i].exp_w0);
    end
    // The stray request was dropped, not queued
    step();
    check("poke_not_queued_valid", {31'd0, mem_valid}, 32'd0);
    check("poke_not_queued_busy", {31'd0, mem_busy}, 32'd0);
    step();
    check("poke_not_queued_valid2", {31'd0, mem_valid}, 32'd0);

    // Simultaneous read and write: the write wins
    for (int k = 0; k < BW; k++) wbuf[k] = 32'hBEEF0000 + 32'(k);
    do_write(32'h0000_2000, -1, 0, 1'b1);
    do_read(32'h0000_2000, 0, w0);
    check("rw_tie_word0", w0, 32'hBEEF0000);

    // Stalled write: mem_wen low for 3 cycles after word 10
    for (int k = 0; k < BW; k++) wbuf[k] = $urandom;
    do_write(32'h0000_3008, 10, 3, 1'b0);
    do_read(32'h0000_3000, 0, w0);
    check("stall_word0", w0, wbuf[0]);

    // Reset during word 5 of a read
    mem_ren  = 1'b1;
    mem_addr = 32'h0000_1000;
    for (int j = 1; j <= LAT + 5; j++) begin
      step();
      mem_ren  = 1'b0;
      mem_addr = $urandom;
    end
    check("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
    check("pre_rst_word5", mem_dout, ref_mem[model_base(32'h1000) + 5]);
    rst = 1'b1;
    step();
    check("mid_rst_valid", {31'd0, mem_valid}, 32'd0);
    check("mid_rst_last", {31'd0, mem_last}, 32'd0);
    check("mid_rst_busy", {31'd0, mem_busy}, 32'd0);
    check("mid_rst_ack", {31'd0, mem_ack}, 32'd0);
    check("mid_rst_dout", mem_dout, 32'd0);
    rst  = 1'b0;
    n_rd = 0;
    n_wr = 0;

    // New read right after reset, then 1 write + 1 read for the block counters
    do_read(32'h0000_3000, 0, w0);
    check("post_rst_word0", w0, ref_mem[model_base(32'h3000)]);
    for (int k = 0; k < BW; k++) wbuf[k] = $urandom;
    do_write(32'h0000_6000, -1, 0, 1'b0);
    do_read(32'h0000_6000, 0, w0);
    check("raw_word0", w0, wbuf[0]);
`ifdef MEM_RESP_STATS_EN
    check("stats_rd_blocks", rd_blocks, 32'd2);
    check("stats_wr_blocks", wr_blocks, 32'd1);
`endif

    // Randomized transactions against the reference model
    last_wr_addr = 32'h0000_6000;
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BW; k++) wbuf[k] = $urandom;
        a = $urandom;
        do_write(a, int'($urandom_range(0, BW - 2)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        last_wr_addr = a;
      end else begin
        // Half the reads target the most recently written block.
        if ($urandom_range(0, 1) == 1) a = last_wr_addr ^ (32'($urandom_range(0, BW - 1)) << 2);
        else a = $urandom;
        do_read(a, int'($urandom_range(0, LAT + BW - 1)), w0);
      end
    end

`ifdef MEM_RESP_STATS_EN
    check("final_rd_blocks", rd_blocks, 32'(n_rd));
    check("final_wr_blocks", wr_blocks, 32'(n_wr));
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
